// File: rtl/spm_seq_ctrl_if.sv
// Host-side handshake bundle for spm_seq_ctrl: operand request channel and result channel.
interface spm_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/spm_seq_ctrl.sv
// Operation sequencer for the serial-parallel multiplier: feeds one operand pair, collects the 2*WIDTH-bit product.
// Optional feature macro SPM_SEQ_CTRL_FLUSH_EN adds a WIDTH-cycle FLUSH state after each result handoff.
module spm_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int P_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    spm_seq_ctrl_if.slave    bus,
    output logic             busy,
    output logic [WIDTH-1:0] spm_x,
    output logic             spm_y,
    input  logic             spm_p
);
    localparam int SHIFT_LEN = 2 * WIDTH + P_LAT;
    localparam int CNT_W     = $clog2(SHIFT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(P_LAT);

`ifdef SPM_SEQ_CTRL_FLUSH_EN
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [2*WIDTH-1:0] result_q;
    logic               out_valid_q;
    logic               handoff;

    assign bus.in_ready  = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign handoff       = out_valid_q && bus.out_ready;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.in_valid) state_d = SHIFT;
            SHIFT: if (cnt_q == CNT_LAST) state_d = DONE;
`ifdef SPM_SEQ_CTRL_FLUSH_EN
            DONE:  if (handoff) state_d = FLUSH;
            FLUSH: if (cnt_q == FLUSH_LAST) state_d = IDLE;
`else
            DONE:  if (handoff) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            b_sr_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            spm_x       <= '0;
            spm_y       <= 1'b0;
        end else begin
            state_q     <= state_d;
            // Registered out_valid rises one cycle after DONE is entered and drops on handoff.
            out_valid_q <= (state_q == DONE) && (state_d == DONE);
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt_q    <= '0;
                        result_q <= '0;
                        spm_x    <= bus.op_a;
                        spm_y    <= bus.op_b[0];
                        b_sr_q   <= bus.op_b >> 1;
                    end
                end
                SHIFT: begin
                    // Product bit k is on spm_p when cnt == k + P_LAT.
                    if (cnt_q >= CNT_CAP) begin
                        result_q <= {spm_p, result_q[2*WIDTH-1:1]};
                    end
                    // The shift register empties after WIDTH bits, so spm_y zero-extends the multiplier.
                    spm_y  <= b_sr_q[0];
                    b_sr_q <= b_sr_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        spm_x <= '0;
                        spm_y <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: cnt_q <= '0;
`ifdef SPM_SEQ_CTRL_FLUSH_EN
                FLUSH: cnt_q <= (cnt_q == FLUSH_LAST) ? '0 : cnt_q + 1'b1;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Self-checking bench for spm_seq_ctrl with a behavioural serial-parallel multiplier model on spm_p.
module tb_spm_seq_ctrl;
    localparam int W     = 32;
    localparam int P_LAT = 1;
    localparam int LAT   = 2 * W + P_LAT + 1;
`ifdef SPM_SEQ_CTRL_FLUSH_EN
    localparam int       SPACING   = W + 1;
    localparam bit       BUSY_POST = 1'b1;
`else
    localparam int       SPACING   = 1;
    localparam bit       BUSY_POST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         busy;
    logic [W-1:0] spm_x;
    logic         spm_y;
    logic         spm_p;
    int           pass_cnt  = 0;
    int           total_cnt = 0;

    spm_seq_ctrl_if #(.WIDTH(W)) bus ();

    spm_seq_ctrl #(.WIDTH(W), .P_LAT(P_LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .spm_x (spm_x),
        .spm_y (spm_y),
        .spm_p (spm_p)
    );

    always #5 clk = ~clk;

    // Multiplier model: after n serial bits, product bit (n - P_LAT) of x * (bits seen so far) is on spm_p.
    logic [127:0] y_hist;
    logic [127:0] prod;
    int           n_bits;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_hist <= '0;
            n_bits <= 0;
        end else if (bus.in_valid && bus.in_ready) begin
            y_hist <= '0;
            n_bits <= 0;
        end else if (n_bits < 2 * W + P_LAT + 8) begin
            y_hist[n_bits] <= spm_y;
            n_bits         <= n_bits + 1;
        end
    end

    always_comb begin
        prod  = 128'(spm_x) * (y_hist | (128'(spm_y) << n_bits));
        spm_p = (n_bits >= P_LAT) ? prod[n_bits - P_LAT] : 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Offers a pair, waits for acceptance, then for out_valid; lat counts edges from the accept edge.
    task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                                  output logic [W-1:0] fx, output logic fy, output bit ok);
        int k;
        k   = 0;
        ok  = 1'b0;
        lat = 0;
        fx  = '0;
        fy  = 1'b0;
        @(negedge clk);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        while (bus.in_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (bus.in_ready !== 1'b1) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        fx = spm_x;
        fy = spm_y;
        while (bus.out_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        ok = (bus.out_valid === 1'b1);
    endtask

    task automatic do_handoff();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*W+W+4:0] got, exp;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got = {bus.in_ready, bus.out_valid, busy, bus.result, spm_x, spm_y};
        exp = {1'b1, 1'b0, 1'b0, {(2*W){1'b0}}, {W{1'b0}}, 1'b0};
        total_cnt++;
        if (got !== exp) $display("FAIL reset_values: got %h expected %h", got, exp);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.in_ready, busy, bus.out_valid} !== 3'b100)
            $display("FAIL reset_release: in_ready/busy/out_valid got %b expected 100",
                     {bus.in_ready, busy, bus.out_valid});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int           lat;
        logic [W-1:0] fx;
        logic         fy;
        bit           ok;
        logic [2*W-1:0] res;
        issue_and_wait(32'd3, 32'd5, lat, fx, fy, ok);
        total_cnt++;
        if (!ok || lat != LAT) $display("FAIL basic_latency: got %0d (ok=%0b) expected %0d", lat, ok, LAT);
        else pass_cnt++;
        total_cnt++;
        if (fx !== 32'd3 || fy !== 1'b1) $display("FAIL basic_first_bit: spm_x=%h spm_y=%b expected 3 1", fx, fy);
        else pass_cnt++;
        res = bus.result;
        do_handoff();
        total_cnt++;
        if (res !== 64'd15) $display("FAIL basic_result: got %h expected %h", res, 64'd15);
        else pass_cnt++;
        total_cnt++;
        if (busy !== BUSY_POST || bus.out_valid !== 1'b0)
            $display("FAIL basic_post_handoff: busy=%b out_valid=%b expected %b 0", busy, bus.out_valid, BUSY_POST);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b, fx;
        logic           fy;
        logic [2*W-1:0] res, exp;
        int             lat, delay;
        bit             ok;
        for (int i = 0; i < 16; i++) begin
            a = $urandom();
            b = $urandom();
            case (i)
                0: begin a = '1; b = '1; end
                1: a = '0;
                2: b = '0;
                3: begin a = 32'h1; b = 32'h1; end
                4: b = b & $urandom() & $urandom();
                default: ;
            endcase
            exp   = mul_ref(a, b);
            delay = $urandom_range(0, 3);
            issue_and_wait(a, b, lat, fx, fy, ok);
            total_cnt++;
            if (!ok || lat != LAT) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LAT);
            else pass_cnt++;
            total_cnt++;
            if (fx !== a || fy !== b[0])
                $display("FAIL rand_first_bit[%0d]: spm_x=%h spm_y=%b expected %h %b", i, fx, fy, a, b[0]);
            else pass_cnt++;
            repeat (delay) @(negedge clk);
            res = bus.result;
            do_handoff();
            total_cnt++;
            if (res !== exp) $display("FAIL rand_result[%0d]: %h*%h got %h expected %h", i, a, b, res, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]   a, b, fx;
        logic           fy;
        logic [2*W-1:0] exp;
        int             lat, bad, extra;
        bit             ok;
        a   = $urandom();
        b   = $urandom();
        exp = mul_ref(a, b);
        bad = 0;
        issue_and_wait(a, b, lat, fx, fy, ok);
        for (int k = 0; k < 100; k++) begin
            if (bus.out_valid !== 1'b1 || bus.result !== exp || bus.in_ready !== 1'b0) bad++;
            bus.in_valid = k[0];
            bus.op_a     = $urandom();
            bus.op_b     = $urandom();
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (!ok || bad != 0) $display("FAIL hold_stable: bad cycles %0d (ok=%0b) expected 0", bad, ok);
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== exp) $display("FAIL hold_result: got %h expected %h", bus.result, exp);
        else pass_cnt++;
        do_handoff();
        extra = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            if (bus.out_valid !== 1'b0) extra++;
            @(negedge clk);
        end
        total_cnt++;
        if (extra != 0) $display("FAIL no_queue: out_valid high %0d cycles expected 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0]     fx;
        logic             fy;
        logic [2*W-1:0]   res;
        logic [2*W+W+4:0] got, exp;
        int               lat;
        bit               ok;
        @(negedge clk);
        bus.op_a     = $urandom();
        bus.op_b     = $urandom();
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        exp = {1'b1, 1'b0, 1'b0, {(2*W){1'b0}}, {W{1'b0}}, 1'b0};
        got = {bus.in_ready, bus.out_valid, busy, bus.result, spm_x, spm_y};
        total_cnt++;
        if (got !== exp) $display("FAIL midreset_async: got %h expected %h", got, exp);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        got = {bus.in_ready, bus.out_valid, busy, bus.result, spm_x, spm_y};
        total_cnt++;
        if (got !== exp) $display("FAIL midreset_held: got %h expected %h", got, exp);
        else pass_cnt++;
        rst = 1'b1;
        issue_and_wait(32'd7, 32'd9, lat, fx, fy, ok);
        res = bus.result;
        do_handoff();
        total_cnt++;
        if (!ok || lat != LAT || res !== 64'd63)
            $display("FAIL midreset_next: result %h latency %0d expected %h %0d", res, lat, 64'd63, LAT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   pa[3];
        logic [W-1:0]   pb[3];
        logic [2*W-1:0] got[3];
        int             acc_edge[3];
        int             hand_edge[3];
        int             n_acc, n_hand;
        bit             acc, hnd;
        pa[0] = 32'h12345678; pb[0] = 32'h9ABCDEF0;
        pa[1] = 32'h00000001; pb[1] = 32'h80000000;
        pa[2] = 32'h0000FFFF; pb[2] = 32'h00010001;
        n_acc  = 0;
        n_hand = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op_a      = pa[0];
        bus.op_b      = pb[0];
        for (int e = 0; e < 1000 && n_hand < 3; e++) begin
            acc = bus.in_valid && bus.in_ready;
            hnd = bus.out_valid && bus.out_ready;
            if (hnd && n_hand < 3) begin
                got[n_hand]       = bus.result;
                hand_edge[n_hand] = e;
                n_hand++;
            end
            if (acc && n_acc < 3) begin
                acc_edge[n_acc] = e;
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (n_acc < 3) begin
                    bus.op_a = pa[n_acc];
                    bus.op_b = pb[n_acc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total_cnt++;
        if (n_hand != 3 || n_acc != 3) $display("FAIL b2b_count: results %0d accepts %0d expected 3 3", n_hand, n_acc);
        else pass_cnt++;
        for (int i = 0; i < n_hand; i++) begin
            total_cnt++;
            if (got[i] !== mul_ref(pa[i], pb[i]))
                $display("FAIL b2b_result[%0d]: got %h expected %h", i, got[i], mul_ref(pa[i], pb[i]));
            else pass_cnt++;
        end
        for (int i = 0; i + 1 < n_acc && i < n_hand; i++) begin
            total_cnt++;
            if (acc_edge[i+1] - hand_edge[i] != SPACING)
                $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, acc_edge[i+1] - hand_edge[i], SPACING);
            else pass_cnt++;
        end
    endtask

`ifdef SPM_SEQ_CTRL_FLUSH_EN
    task automatic test_flush();
        logic [W-1:0] fx;
        logic         fy;
        int           lat, bad;
        bit           ok;
        issue_and_wait($urandom(), $urandom(), lat, fx, fy, ok);
        do_handoff();
        bad = 0;
        for (int k = 0; k < W; k++) begin
            if (spm_x !== '0 || spm_y !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        total_cnt++;
        if (!ok || bad != 0) $display("FAIL flush_window: bad cycles %0d (ok=%0b) expected 0", bad, ok);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL flush_exit: in_ready=%b busy=%b expected 1 0", bus.in_ready, busy);
        else pass_cnt++;
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef SPM_SEQ_CTRL_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spm_seq_ctrl.md
# spm_seq_ctrl

Operation sequencer for the WIDTH-bit serial-parallel multiplier (spm) and its carry-save adder chain. Accepts one unsigned operand pair through a valid/ready handshake. Drives the multiplicand in parallel and the multiplier LSB-first, one bit per clock. Deserialises the 2×WIDTH-bit product from the spm serial output and returns it through a second valid/ready handshake. It sits between the host-side operand interface and the spm datapath, so the datapath never sees a partial or overlapped operation.

## Interface
Parameters:
- WIDTH, 32, operand width; must match the spm instance
- P_LAT, 1, cycles from the first spm_y bit until product bit 0 is on spm_p (0..3)

Ports:
- clk  in  1  rising-edge clock, shared with spm
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  controller can accept an operand pair
- op_a  in  WIDTH  multiplicand (parallel side)
- op_b  in  WIDTH  multiplier (serial side)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  2×WIDTH  product op_a×op_b, unsigned
- busy  out  1  high in any state other than IDLE
- spm_x  out  WIDTH  to spm x
- spm_y  out  1  to spm y
- spm_p  in  1  from spm serial product output

## Operation
- States: IDLE, SHIFT, DONE, FLUSH (FLUSH exists only with the macro).
- IDLE:
  - in_ready=1, spm_x=0, spm_y=0.
  - An accept (in_valid&&in_ready) latches op_a and op_b, clears result and the counter cnt, and enters SHIFT.
- SHIFT:
  - Lasts 2×WIDTH+P_LAT cycles, with cnt=0..2×WIDTH+P_LAT−1.
  - spm_x = latched A throughout.
  - spm_y = B[cnt] for cnt<WIDTH; otherwise 0 (zero-extension drains the carries).
  - For cnt≥P_LAT, spm_p is shifted into the result MSB, with result shifting right. After the last capture, result[0] holds product bit 0.
  - After cnt reaches its final value, go to DONE.
- DONE:
  - out_valid=1, and result is held stable.
  - On out_valid&&out_ready, go to IDLE, or to FLUSH when the macro is compiled in.
- in_ready=0 in SHIFT, DONE and FLUSH. Input requests are ignored there; the controller does not queue.
- cnt is an unsigned counter of width $clog2(2×WIDTH+P_LAT+1). Its saturating end value is checked explicitly, and it never wraps during an operation.
- Reset mid-operation (rst low in any state):
  - Immediate return to IDLE; all outputs take their reset values; the latched operands are discarded.
  - The spm shares rst, so its internal state is cleared simultaneously.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, spm_x=0, spm_y=0, state=IDLE.
- Accept at edge t:
  - The first spm_y bit is driven in cycle t+1.
  - out_valid rises at edge t+2×WIDTH+P_LAT+1. For WIDTH=32, P_LAT=1 this is 66 cycles.
- out_valid is held with result stable until out_ready. Backpressure is unbounded.
- Back-to-back throughput without the macro:
  - The result is consumed at edge d, in_ready is high in cycle d+1, and the next accept is at edge d+1 at the earliest.
  - One idle cycle separates operations.
- All outputs are registered, except in_ready and busy, which are decoded combinationally from the state register.

## Configuration
- SPM_SEQ_CTRL_FLUSH_EN defined:
  - After each result handoff, FLUSH runs WIDTH cycles with spm_x=0, spm_y=0, in_ready=0, busy=1, then returns to IDLE.
  - This guarantees a zero spm state even if spm is replaced by a signed or non-draining variant.
  - Back-to-back spacing becomes WIDTH+1 cycles.
- Macro undefined:
  - The FLUSH state and its counter compare are absent; DONE goes directly to IDLE.
  - Correct only because the zero-extended multiplier fully drains the unsigned spm within SHIFT.

## Test plan
- Reset release, then op_a=3, op_b=5 with out_ready=1 → out_valid after 66 cycles (WIDTH=32, P_LAT=1), result=15, busy low the cycle after handoff.
- op_a=op_b=0xFFFFFFFF → result=0xFFFFFFFE00000001; op_a=0 or op_b=0 → result=0.
- out_ready held low for 100 cycles after out_valid → result and out_valid stable; in_ready=0; in_valid pulses are ignored (no second result).
- rst asserted at SHIFT cnt=20, released, then 7×9 issued → outputs at reset values during rst; result=63; no residue from the aborted operation.
- Three back-to-back pairs (0x12345678×0x9ABCDEF0, 1×0x80000000, 0xFFFF×0x10001) with in_valid held high → results 0x0B00EA4E242D2080, 0x80000000, 0xFFFFFFFF; spacing of 1 idle cycle, or WIDTH+1 cycles with SPM_SEQ_CTRL_FLUSH_EN.
- With SPM_SEQ_CTRL_FLUSH_EN: spm_x=0 and spm_y=0 for exactly 32 cycles after handoff, with in_ready=0 throughout, then in_ready=1.
